tensor_product_scheduler: RTL



---
 rtl/tensor_product_pkg.sv | 31 +++
 rtl/tensor_product_scheduler_if.sv | 47 ++++
 rtl/tile_multiplier.sv | 28 ++
 rtl/tensor_product_scheduler.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/tensor_product_pkg.sv
// Shared types and elaboration-time helpers for the tensor product scheduler.
// Holds the FSM state enum, a ceil-divide, a clog2 that never drops below
// one bit, and the row/column tile-count computations.
package tensor_product_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // Index widths must stay at least one bit, even for a count of 1.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int row_tiles(input int vector_size, input int tiling_v);
        return ceil_div(vector_size, tiling_v);
    endfunction

    function automatic int col_tiles(input int vector_size, input int tiling_h);
        return ceil_div(vector_size, tiling_h);
    endfunction

endpackage

// File: rtl/tensor_product_scheduler_if.sv
// Request and tile-output channels of the tensor product scheduler.
//   req_valid/req_ready : per-requester handshake, ready is a one-hot grant
//   req_a/req_b         : packed operand vectors, requester i in slice i
//   out_valid/out_ready : tile stream handshake
//   out_data            : tile products, row k col j at (k*TILING_H+j)*2*CELL_WIDTH
//   out_row/out_col     : tile indices, out_id owner, out_last final tile
//   done                : one-cycle completion pulse per requester
// master = requesters/consumer side, slave = scheduler side.
interface tensor_product_scheduler_if #(
    parameter int NUM_REQ     = 2,
    parameter int VECTOR_SIZE = 5,
    parameter int CELL_WIDTH  = 8,
    parameter int TILING_H    = 4,
    parameter int TILING_V    = 1
);
    import tensor_product_pkg::*;

    localparam int ROW_W  = clog2_min1(row_tiles(VECTOR_SIZE, TILING_V));
    localparam int COL_W  = clog2_min1(col_tiles(VECTOR_SIZE, TILING_H));
    localparam int ID_W   = clog2_min1(NUM_REQ);
    localparam int REQ_W  = NUM_REQ * VECTOR_SIZE * CELL_WIDTH;
    localparam int TILE_W = TILING_V * TILING_H * 2 * CELL_WIDTH;

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [REQ_W-1:0]   req_a;
    logic [REQ_W-1:0]   req_b;
    logic               out_valid;
    logic               out_ready;
    logic [TILE_W-1:0]  out_data;
    logic [ROW_W-1:0]   out_row;
    logic [COL_W-1:0]   out_col;
    logic [ID_W-1:0]    out_id;
    logic               out_last;
    logic [NUM_REQ-1:0] done;

    modport master (
        output req_valid, req_a, req_b, out_ready,
        input  req_ready, out_valid, out_data, out_row, out_col, out_id, out_last, done
    );

    modport slave (
        input  req_valid, req_a, req_b, out_ready,
        output req_ready, out_valid, out_data, out_row, out_col, out_id, out_last, done
    );

endinterface

// File: rtl/tile_multiplier.sv
// Combinational TILING_V x TILING_H unsigned outer-product array.
//   tile_a    : TILING_V row operands, cell 0 in the LSBs
//   tile_b    : TILING_H column operands, cell 0 in the LSBs
//   tile_prod : full-width products, row k col j at (k*TILING_H+j)*2*CELL_WIDTH
module tile_multiplier #(
    parameter int CELL_WIDTH = 8,
    parameter int TILING_H   = 4,
    parameter int TILING_V   = 1
) (
    input  logic [TILING_V*CELL_WIDTH-1:0]            tile_a,
    input  logic [TILING_H*CELL_WIDTH-1:0]            tile_b,
    output logic [TILING_V*TILING_H*2*CELL_WIDTH-1:0] tile_prod
);

    localparam int PROD_W = 2 * CELL_WIDTH;

    always_comb begin
        tile_prod = '0;
        for (int k = 0; k < TILING_V; k++) begin
            for (int j = 0; j < TILING_H; j++) begin
                tile_prod[(k*TILING_H+j)*PROD_W +: PROD_W] =
                    PROD_W'(tile_a[k*CELL_WIDTH +: CELL_WIDTH]) *
                    PROD_W'(tile_b[j*CELL_WIDTH +: CELL_WIDTH]);
            end
        end
    end

endmodule

// File: rtl/tensor_product_scheduler.sv
// Time-shares one tiled outer-product multiplier between NUM_REQ requesters.
// A round-robin arbiter accepts one (a, b) job, latches the operands, then
// walks row/column tile counters, presenting one tile of products per cycle
// under backpressure, and pulses done[id] the cycle after the last tile.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : request channel, tile output stream and done pulses (slave)
module tensor_product_scheduler
    import tensor_product_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int VECTOR_SIZE = 5,
    parameter int CELL_WIDTH  = 8,
    parameter int TILING_H    = 4,
    parameter int TILING_V    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    tensor_product_scheduler_if.slave     bus
);

    localparam int ROW_TILES = row_tiles(VECTOR_SIZE, TILING_V);
    localparam int COL_TILES = col_tiles(VECTOR_SIZE, TILING_H);
    localparam int ROW_W     = clog2_min1(ROW_TILES);
    localparam int COL_W     = clog2_min1(COL_TILES);
    localparam int ID_W      = clog2_min1(NUM_REQ);
    localparam int VEC_W     = VECTOR_SIZE * CELL_WIDTH;
    localparam int TILE_W    = TILING_V * TILING_H * 2 * CELL_WIDTH;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_TILES - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL_TILES - 1);

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   a_q, b_q;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   col_q;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [NUM_REQ-1:0] done_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_found;
    int                 scan_idx;
    logic               accept;
    logic               tile_fire;
    logic               last_tile;

    logic [TILING_V*CELL_WIDTH-1:0] tile_a;
    logic [TILING_H*CELL_WIDTH-1:0] tile_b;
    logic [TILE_W-1:0]              tile_prod;
    int                             a_idx, b_idx;

    // Round-robin search starting at rr_ptr; first valid requester wins.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        scan_idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                grant_id        = ID_W'(scan_idx);
                grant_found     = 1'b1;
            end
        end
    end

    // Grants are suppressed while reset is held so req_ready reads 0 then.
    assign accept    = (state_q == IDLE) && grant_found && !rst;
    assign tile_fire = (state_q == RUN) && bus.out_ready;
    assign last_tile = (row_q == ROW_LAST) && (col_q == COL_LAST);

    // Cells past the ragged edge feed a zero operand, so their product is 0.
    always_comb begin
        tile_a = '0;
        tile_b = '0;
        a_idx  = 0;
        b_idx  = 0;
        for (int k = 0; k < TILING_V; k++) begin
            a_idx = int'(row_q) * TILING_V + k;
            if (a_idx < VECTOR_SIZE)
                tile_a[k*CELL_WIDTH +: CELL_WIDTH] = a_q[a_idx*CELL_WIDTH +: CELL_WIDTH];
        end
        for (int j = 0; j < TILING_H; j++) begin
            b_idx = int'(col_q) * TILING_H + j;
            if (b_idx < VECTOR_SIZE)
                tile_b[j*CELL_WIDTH +: CELL_WIDTH] = b_q[b_idx*CELL_WIDTH +: CELL_WIDTH];
        end
    end

    tile_multiplier #(
        .CELL_WIDTH (CELL_WIDTH),
        .TILING_H   (TILING_H),
        .TILING_V   (TILING_V)
    ) u_tile_multiplier (
        .tile_a    (tile_a),
        .tile_b    (tile_b),
        .tile_prod (tile_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (tile_fire && last_tile) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            row_q    <= '0;
            col_q    <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
            done_q   <= '0;
        end else begin
            done_q <= '0;
            if (accept) begin
                a_q      <= bus.req_a[int'(grant_id)*VEC_W +: VEC_W];
                b_q      <= bus.req_b[int'(grant_id)*VEC_W +: VEC_W];
                id_q     <= grant_id;
                row_q    <= '0;
                col_q    <= '0;
                rr_ptr_q <= ID_W'((int'(grant_id) + 1) % NUM_REQ);
            end else if (tile_fire) begin
                if (last_tile) begin
                    // Counters return to 0 so IDLE outputs match reset values.
                    row_q        <= '0;
                    col_q        <= '0;
                    done_q[id_q] <= 1'b1;
                end else if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    assign bus.req_ready = accept ? grant : '0;
    assign bus.out_valid = (state_q == RUN);
    assign bus.out_data  = tile_prod;
    assign bus.out_row   = row_q;
    assign bus.out_col   = col_q;
    assign bus.out_id    = id_q;
    assign bus.out_last  = (state_q == RUN) && last_tile;
    assign bus.done      = done_q;

endmodule
